// File: rtl/sram_1r1w_mask_init_pkg.sv
// Shared definitions for the 1R1W masked SRAM model: lane geometry defaults,
// init FSM state encoding and the legal read-latency range.
package sram_1r1w_mask_init_pkg;

    localparam int unsigned DEF_LANES    = 10;
    localparam int unsigned DEF_LANE_W   = 6;
    localparam int unsigned READ_LAT_MIN = 1;
    localparam int unsigned READ_LAT_MAX = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } init_state_t;

    // Word width derived from the lane geometry.
    function automatic int unsigned data_width(input int unsigned lanes, input int unsigned lane_w);
        return lanes * lane_w;
    endfunction

endpackage

// File: rtl/sram_lane_merge.sv
// Combinational per-lane merge: lanes whose mask bit is set take new_data,
// the rest keep old_word. Shared by the array write and read-forward paths.
module sram_lane_merge #(
    parameter int unsigned LANES  = 10,
    parameter int unsigned LANE_W = 6
) (
    input  logic [LANES*LANE_W-1:0] old_word,
    input  logic [LANES*LANE_W-1:0] new_data,
    input  logic [LANES-1:0]        mask,
    output logic [LANES*LANE_W-1:0] merged
);

    // Lane-by-lane select between stored and incoming data.
    always_comb begin
        merged = old_word;
        for (int i = 0; i < int'(LANES); i++) begin
            if (mask[i]) begin
                merged[i*LANE_W +: LANE_W] = new_data[i*LANE_W +: LANE_W];
            end else begin
                merged[i*LANE_W +: LANE_W] = old_word[i*LANE_W +: LANE_W];
            end
        end
    end

endmodule

// File: rtl/sram_1r1w_mask_init.sv
// Dual-port (1R1W) masked SRAM model with write-first same-address forwarding,
// 1- or 2-cycle registered read latency and a post-reset zero-fill sweep.
module sram_1r1w_mask_init
    import sram_1r1w_mask_init_pkg::*;
#(
    parameter  int unsigned DEPTH    = 1024,
    parameter  int unsigned ADDR_W   = 10,
    parameter  int unsigned LANES    = DEF_LANES,
    parameter  int unsigned LANE_W   = DEF_LANE_W,
    parameter  int unsigned READ_LAT = READ_LAT_MIN,
    parameter  int unsigned INIT_EN  = 1,
    localparam int unsigned DATA_W   = data_width(LANES, LANE_W)
) (
    input  logic              clock,
    input  logic              reset,
    output logic              init_busy,
    input  logic              R0_en,
    input  logic [ADDR_W-1:0] R0_addr,
    output logic              R0_valid,
    output logic [DATA_W-1:0] R0_rdata,
    input  logic              W0_en,
    input  logic [ADDR_W-1:0] W0_addr,
    input  logic [LANES-1:0]  W0_mask,
    input  logic [DATA_W-1:0] W0_data
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_r [DEPTH];

    init_state_t       state_r;
    init_state_t       state_nx_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [ADDR_W-1:0] cnt_nx_s;
    logic              busy_r;

    logic              rd_issue_s;
    logic              wr_go_s;
    logic              sweep_wr_s;
    logic [DATA_W-1:0] wr_old_s;
    logic [DATA_W-1:0] wr_word_s;
    logic [DATA_W-1:0] rd_old_s;
    logic [LANES-1:0]  fwd_mask_s;
    logic [DATA_W-1:0] rd_word_s;

    logic              s1_valid_r;
    logic [DATA_W-1:0] s1_data_r;

    // Init FSM next-state: sweep one word per cycle until the last address.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            SWEEP: begin
                cnt_nx_s = cnt_r + ADDR_W'(1);
                if (cnt_r == LAST_ADDR) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = SWEEP;
                end
            end
            IDLE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Init FSM state, sweep counter and busy flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= (INIT_EN != 0) ? SWEEP : IDLE;
            cnt_r   <= '0;
            busy_r  <= (INIT_EN != 0);
        end else begin
            state_r <= state_nx_s;
            cnt_r   <= cnt_nx_s;
            busy_r  <= (state_nx_s == SWEEP);
        end
    end

    assign init_busy  = busy_r;
    assign rd_issue_s = R0_en & ~busy_r & ~reset;
    assign wr_go_s    = W0_en & ~busy_r & ~reset;
    assign sweep_wr_s = busy_r & ~reset;

    assign wr_old_s   = mem_r[W0_addr];
    assign rd_old_s   = mem_r[R0_addr];
    assign fwd_mask_s = (wr_go_s && (W0_addr == R0_addr)) ? W0_mask : '0;

    sram_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_wr_merge (
        .old_word (wr_old_s),
        .new_data (W0_data),
        .mask     (W0_mask),
        .merged   (wr_word_s)
    );

    // Forwarding reuses the merge so a colliding read sees the post-write word.
    sram_lane_merge #(.LANES(LANES), .LANE_W(LANE_W)) u_fwd_merge (
        .old_word (rd_old_s),
        .new_data (W0_data),
        .mask     (fwd_mask_s),
        .merged   (rd_word_s)
    );

    // Array write port: sweep zero-fill has priority, otherwise masked write.
    always_ff @(posedge clock) begin
        if (sweep_wr_s) begin
            mem_r[cnt_r] <= '0;
        end else if (wr_go_s) begin
            mem_r[W0_addr] <= wr_word_s;
        end
    end

    // First read stage: data captured at issue and held until the next issue.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= '0;
        end else begin
            s1_valid_r <= rd_issue_s;
            if (rd_issue_s) begin
                s1_data_r <= rd_word_s;
            end
        end
    end

    generate
        if (READ_LAT == 2) begin : g_lat2
            logic              s2_valid_r;
            logic [DATA_W-1:0] s2_data_r;

            // Extra output stage; valid and data move together.
            always_ff @(posedge clock) begin
                if (reset) begin
                    s2_valid_r <= 1'b0;
                    s2_data_r  <= '0;
                end else begin
                    s2_valid_r <= s1_valid_r;
                    if (s1_valid_r) begin
                        s2_data_r <= s1_data_r;
                    end
                end
            end

            assign R0_valid = s2_valid_r;
            assign R0_rdata = s2_data_r;
        end else begin : g_lat1
            assign R0_valid = s1_valid_r;
            assign R0_rdata = s1_data_r;
        end
    endgenerate

endmodule

// File: tb/tb_sram_1r1w_mask_init.sv
// Bench for sram_1r1w_mask_init: two instances (read latency 1 and 2) share
// the stimulus and are checked every cycle against a word-level array model.
module tb_sram_1r1w_mask_init;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LN    = 10;
    localparam int LW    = 6;
    localparam int DW    = LN * LW;

    logic          clock = 1'b0;
    logic          reset;
    logic          R0_en;
    logic [AW-1:0] R0_addr;
    logic          W0_en;
    logic [AW-1:0] W0_addr;
    logic [LN-1:0] W0_mask;
    logic [DW-1:0] W0_data;

    logic          busy1, valid1, busy2, valid2;
    logic [DW-1:0] rdata1, rdata2;

    sram_1r1w_mask_init #(.DEPTH(DEPTH), .ADDR_W(AW), .LANES(LN), .LANE_W(LW),
                          .READ_LAT(1), .INIT_EN(1)) dut1 (
        .clock(clock), .reset(reset), .init_busy(busy1),
        .R0_en(R0_en), .R0_addr(R0_addr), .R0_valid(valid1), .R0_rdata(rdata1),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_mask(W0_mask), .W0_data(W0_data)
    );

    sram_1r1w_mask_init #(.DEPTH(DEPTH), .ADDR_W(AW), .LANES(LN), .LANE_W(LW),
                          .READ_LAT(2), .INIT_EN(1)) dut2 (
        .clock(clock), .reset(reset), .init_busy(busy2),
        .R0_en(R0_en), .R0_addr(R0_addr), .R0_valid(valid2), .R0_rdata(rdata2),
        .W0_en(W0_en), .W0_addr(W0_addr), .W0_mask(W0_mask), .W0_data(W0_data)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: array, remaining sweep cycles, expected outputs by latency.
    logic [DW-1:0] mem_m [DEPTH];
    int            busy_left = 0;
    bit            exp_v [2];
    logic [DW-1:0] exp_d [2];
    bit            started = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nd,
                                            input logic [LN-1:0] m);
        logic [DW-1:0] w;
        w = old;
        for (int i = 0; i < LN; i++)
            if (m[i]) w[i*LW +: LW] = nd[i*LW +: LW];
        return w;
    endfunction

    // Advance the model by one clock edge using the inputs seen at that edge.
    task automatic model_step();
        logic [DW-1:0] rd;
        bit            issued;
        rd     = '0;
        issued = 1'b0;
        if (reset) begin
            busy_left = DEPTH;
            exp_v[0]  = 1'b0;
            exp_v[1]  = 1'b0;
            exp_d[0]  = '0;
            exp_d[1]  = '0;
            started   = 1'b1;
        end else begin
            if (busy_left > 0) begin
                mem_m[DEPTH - busy_left] = '0;
                busy_left--;
            end else begin
                if (R0_en) begin
                    rd = mem_m[R0_addr];
                    if (W0_en && W0_addr == R0_addr) rd = merge(rd, W0_data, W0_mask);
                    issued = 1'b1;
                end
                if (W0_en) mem_m[W0_addr] = merge(mem_m[W0_addr], W0_data, W0_mask);
            end
            if (exp_v[0]) exp_d[1] = exp_d[0];
            exp_v[1] = exp_v[0];
            exp_v[0] = issued;
            if (issued) exp_d[0] = rd;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic drive(input bit re, input int ra, input bit we, input int wa,
                         input logic [LN-1:0] wm, input logic [DW-1:0] wd);
        R0_en   = re;
        R0_addr = AW'(ra);
        W0_en   = we;
        W0_addr = AW'(wa);
        W0_mask = wm;
        W0_data = wd;
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, '0, '0);
    endtask

    task automatic busy_len(input string nm);
        int n;
        n = 0;
        while (busy1 && n < 40) begin
            cyc();
            n++;
        end
        check(nm, 64'(n), 64'(DEPTH));
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        if (started) begin
            check("busy_l1", 64'(busy1), 64'(busy_left > 0));
            check("busy_l2", 64'(busy2), 64'(busy_left > 0));
            check("valid_l1", 64'(valid1), 64'(exp_v[0]));
            check("valid_l2", 64'(valid2), 64'(exp_v[1]));
            check("rdata_l1", 64'(rdata1), 64'(exp_d[0]));
            check("rdata_l2", 64'(rdata2), 64'(exp_d[1]));
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        idle();
        cyc();
        cyc();
        check("reset_valid", 64'(valid1), 64'd0);
        check("reset_rdata", 64'(rdata2), 64'd0);
        check("reset_busy", 64'(busy1), 64'd1);
        reset = 1'b0;
        busy_len("sweep_len");

        // Every word reads back zero after the sweep.
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, i, 1'b0, 0, '0, '0);
            cyc();
        end
        idle();
        cyc();
        cyc();

        // Masked write: lanes 0 and 2 only.
        drive(1'b0, 0, 1'b1, 5, 10'b0000000101, {DW{1'b1}});
        cyc();
        drive(1'b1, 5, 1'b0, 0, '0, '0);
        cyc();
        check("mask_l1", 64'(rdata1), 64'h0000_0000_0003_F03F);
        idle();
        cyc();
        check("mask_l2", 64'(rdata2), 64'h0000_0000_0003_F03F);

        // Same-cycle collision, write-first on the masked lane.
        drive(1'b0, 0, 1'b1, 3, 10'h3FF, 60'h0AAAAAAAAAAAAAAA);
        cyc();
        drive(1'b1, 3, 1'b1, 3, 10'b0000000001, 60'h15);
        cyc();
        check("collide_l1", 64'(rdata1), 64'h0AAA_AAAA_AAAA_AA95);
        idle();
        cyc();
        check("collide_l2", 64'(rdata2), 64'h0AAA_AAAA_AAAA_AA95);

        // A later write does not disturb a captured read.
        drive(1'b0, 0, 1'b1, 7, 10'h3FF, 60'h123);
        cyc();
        drive(1'b1, 7, 1'b0, 0, '0, '0);
        cyc();
        drive(1'b0, 0, 1'b1, 7, 10'h3FF, 60'h456);
        cyc();
        check("war_l1_hold", 64'(rdata1), 64'h123);
        check("war_l2", 64'(rdata2), 64'h123);
        drive(1'b1, 7, 1'b0, 0, '0, '0);
        cyc();
        idle();
        cyc();
        check("war_new_l2", 64'(rdata2), 64'h456);

        // Back-to-back reads.
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 0, 1'b1, i, 10'h3FF, DW'(i * 'h111));
            cyc();
        end
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, i, 1'b0, 0, '0, '0);
            cyc();
        end
        check("b2b_l1_third", 64'(rdata1), 64'h333);
        check("b2b_l2_second", 64'(rdata2), 64'h222);
        idle();
        cyc();
        check("b2b_l2_third", 64'(rdata2), 64'h333);
        cyc();
        check("b2b_l2_idle", 64'(valid2), 64'd0);

        // Reset with a read in flight, then reset again mid-sweep.
        drive(1'b1, 5, 1'b0, 0, '0, '0);
        cyc();
        reset = 1'b1;
        idle();
        cyc();
        check("rst_drop_l2", 64'(valid2), 64'd0);
        reset = 1'b0;
        drive(1'b1, 2, 1'b1, 2, 10'h3FF, {DW{1'b1}});
        for (int i = 0; i < 9; i++) cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        busy_len("resweep_len");
        idle();
        drive(1'b1, 2, 1'b0, 0, '0, '0);
        cyc();
        check("busy_nowrite", 64'(rdata1), 64'd0);
        drive(1'b1, 5, 1'b0, 0, '0, '0);
        cyc();
        check("resweep_zero", 64'(rdata1), 64'd0);
        idle();
        cyc();
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
